button_press_counter_top: RTL and testbench
===========================================

Name: button_press_counter_top

Overview:
Top level of the button-press counter. Counts rising edges on three push-buttons into three 4-bit counters, gated by a debounced activator switch. Three equalizer switches let a press copy the leading count instead of incrementing. Results go to one seven-segment digit (display) and a 10-LED bar (indicator).

Parameters:
DEBOUNCE_CYCLES, 4, consecutive post-sync cycles an input must hold a new level before the debounced value changes
SYNC_STAGES, 2, synchronizer flops on every asynchronous input (min 2)

Ports:
clk  input  1  system clock, 50 MHz nominal, all state on rising edge
rst  input  1  asynchronous, active-high reset
activator  input  1  enable switch, debounced internally; 1 = counting enabled
buttons  input  3  push-buttons, active-high; button i drives counter i
equalizer  input  3  mode switches; equalizer[i]=1 makes a press on button i equalize instead of increment
display  output  8  [6:0] active-low seven-segment (a=bit0 … g=bit6) of last-updated counter, hex 0-F; [7] = 1 when all three counters are equal
indicator  output  10  thermometer of total presses (sum of counters, clamped to 10), LSB first

Behaviour:
- Reset (async, rst=1): cnt0..cnt2=0, last-updated index=0, debounced activator=0, synchronizers and edge registers=0. Outputs during/after reset: display=8'hC0 (digit 0, bit7=1 since all equal), indicator=0.
- Inputs pass through SYNC_STAGES flops. buttons and equalizer are only synchronized. activator is synchronized, then debounced: internal act_db takes the new level after DEBOUNCE_CYCLES consecutive identical synced samples differing from act_db.
- Press event i = synced button[i] is 1 now and was 0 last cycle (one-cycle pulse). A 1-clock-wide input pulse must be counted.
- Latency: input high at edge N → counter updated at edge N+SYNC_STAGES (edge N+2 by default).
- On press event i with act_db=1:
  - equalizer[i]=0: cnt_i <= cnt_i+1, 4-bit wrap (15→0).
  - equalizer[i]=1: cnt_i <= max(cnt0,cnt1,cnt2), using values before this cycle's updates.
  - last-updated index <= i.
- Simultaneous press events: each counter updates independently from pre-cycle values. Last-updated index takes the highest i pressed.
- act_db=0: press events ignored; counters and index hold.
- equalizer level is sampled in the same cycle as the press event.
- Outputs are combinational decode of registered state (no added latency).
- Total for indicator = cnt0+cnt1+cnt2 (6-bit). indicator[k]=1 iff total > k, k=0..9.
- A press held high counts once. Release produces no event.

Optional Feature:
BPC_DEBOUNCE_BUTTONS_EN
- Defined: buttons also pass through the DEBOUNCE_CYCLES debouncer before edge detection. Press latency becomes SYNC_STAGES+DEBOUNCE_CYCLES. Pulses shorter than DEBOUNCE_CYCLES are dropped.
- Undefined: buttons are synchronized only, per Behaviour.

Test Plan:
- Reset: assert rst mid-run with counters nonzero → counters 0, display=8'hC0, indicator=10'h000 immediately (asynchronous).
- Count: activator=1 held 10 cycles, three 1-cycle pulses on buttons[2] → cnt2=3, display[6:0]=7'b0110000 ("3"), display[7]=0, indicator=10'b0000000111. Each update lands 2 edges after the sampled pulse.
- Equalize: continue with equalizer[0]=1, one pulse on buttons[0] → cnt0=3, cnt1=0, display shows "3", display[7]=0, indicator=10'b0000111111.
- Gate: drop activator for 10 cycles, pulse buttons[1] → no change. Also drop activator for only 2 cycles → act_db stays 1, a press during that window is counted.
- Wrap and clamp: 16 presses on buttons[1] → cnt1=0. Sum ≥10 → indicator=10'h3FF.
- Simultaneous: pulse buttons[0] and buttons[1] together from 2/5/0 with equalizer=3'b001 → cnt0=5, cnt1=6, display shows "6".

Source files
------------

// File: rtl/button_press_counter_top.sv
// Button-press counter: three gated 4-bit counters shown on a 7-seg digit and LED bar.
// Optional: define BPC_DEBOUNCE_BUTTONS_EN to debounce the buttons as well as the activator.

module button_press_counter_top #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       activator,
   input  logic [2:0] buttons,
   input  logic [2:0] equalizer,
   output logic [7:0] display,
   output logic [9:0] indicator
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef BPC_DEBOUNCE_BUTTONS_EN
   localparam int NDB = 4;
`else
   localparam int NDB = 1;
`endif

   logic [SYNC_STAGES-1:0]      r_act_sync;
   logic [SYNC_STAGES-1:0][2:0] r_btn_sync;
   logic [SYNC_STAGES-1:0][2:0] r_eq_sync;
   logic                        w_act_sync;
   logic [2:0]                  w_btn_sync;
   logic [2:0]                  w_eq_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_act_sync <= '0;
         r_btn_sync <= '0;
         r_eq_sync  <= '0;
      end else begin
         r_act_sync <= {r_act_sync[SYNC_STAGES-2:0], activator};
         r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], buttons};
         r_eq_sync  <= {r_eq_sync[SYNC_STAGES-2:0], equalizer};
      end
   end

   assign w_act_sync = r_act_sync[SYNC_STAGES-1];
   assign w_btn_sync = r_btn_sync[SYNC_STAGES-1];
   assign w_eq_sync  = r_eq_sync[SYNC_STAGES-1];

   // Debouncer bank: lane 0 is the activator, lanes 3:1 the buttons when enabled.
   logic [NDB-1:0] w_db_in;
   logic [NDB-1:0] r_db_q;
   logic [DBW-1:0] r_db_cnt [NDB];
   logic           w_act_db;
   logic [2:0]     w_btn_clean;

`ifdef BPC_DEBOUNCE_BUTTONS_EN
   assign w_db_in     = {w_btn_sync, w_act_sync};
   assign w_btn_clean = r_db_q[3:1];
`else
   assign w_db_in     = w_act_sync;
   assign w_btn_clean = w_btn_sync;
`endif
   assign w_act_db = r_db_q[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_db_q <= '0;
         for (int j = 0; j < NDB; j++) r_db_cnt[j] <= '0;
      end else begin
         for (int j = 0; j < NDB; j++) begin
            if (w_db_in[j] == r_db_q[j]) begin
               r_db_cnt[j] <= '0;
            end else if (r_db_cnt[j] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               r_db_q[j]   <= w_db_in[j];
               r_db_cnt[j] <= '0;
            end else begin
               r_db_cnt[j] <= r_db_cnt[j] + 1'b1;
            end
         end
      end
   end

   logic [2:0] r_btn_prev;
   logic [2:0] w_press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_btn_prev <= '0;
      else     r_btn_prev <= w_btn_clean;
   end

   assign w_press = w_btn_clean & ~r_btn_prev;

   logic [3:0] r_cnt [3];
   logic [1:0] r_last;
   logic [3:0] w_max;

   always_comb begin
      w_max = r_cnt[0];
      if (r_cnt[1] > w_max) w_max = r_cnt[1];
      if (r_cnt[2] > w_max) w_max = r_cnt[2];
   end

   // All lanes read pre-edge counts, so simultaneous presses stay independent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
         r_last <= '0;
      end else if (w_act_db) begin
         for (int i = 0; i < 3; i++) begin
            if (w_press[i]) begin
               r_cnt[i] <= w_eq_sync[i] ? w_max : r_cnt[i] + 4'd1;
               r_last   <= 2'(i);
            end
         end
      end
   end

   logic [3:0] w_sel;
   logic [6:0] w_seg;
   logic       w_all_eq;
   logic [5:0] w_total;

   always_comb begin
      case (r_last)
         2'd1:    w_sel = r_cnt[1];
         2'd2:    w_sel = r_cnt[2];
         default: w_sel = r_cnt[0];
      endcase
   end

   always_comb begin
      case (w_sel)
         4'h0:    w_seg = 7'b1000000;
         4'h1:    w_seg = 7'b1111001;
         4'h2:    w_seg = 7'b0100100;
         4'h3:    w_seg = 7'b0110000;
         4'h4:    w_seg = 7'b0011001;
         4'h5:    w_seg = 7'b0010010;
         4'h6:    w_seg = 7'b0000010;
         4'h7:    w_seg = 7'b1111000;
         4'h8:    w_seg = 7'b0000000;
         4'h9:    w_seg = 7'b0010000;
         4'hA:    w_seg = 7'b0001000;
         4'hB:    w_seg = 7'b0000011;
         4'hC:    w_seg = 7'b1000110;
         4'hD:    w_seg = 7'b0100001;
         4'hE:    w_seg = 7'b0000110;
         default: w_seg = 7'b0001110;
      endcase
   end

   assign w_all_eq = (r_cnt[0] == r_cnt[1]) && (r_cnt[1] == r_cnt[2]);
   assign w_total  = {2'b00, r_cnt[0]} + {2'b00, r_cnt[1]} + {2'b00, r_cnt[2]};
   assign display  = {w_all_eq, w_seg};

   always_comb begin
      indicator = '0;
      for (int k = 0; k < 10; k++) indicator[k] = (w_total > 6'(k));
   end

endmodule

// File: tb/tb_button_press_counter_top.sv
// Bench for button_press_counter_top: directed vector table, hand sequences, random vs model.
// Targets the default build (BPC_DEBOUNCE_BUTTONS_EN undefined).

module tb_button_press_counter_top;

   localparam int S = 2;
   localparam int D = 4;
   localparam int L = S + D + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       activator = 1'b0;
   logic [2:0] buttons = '0;
   logic [2:0] equalizer = '0;
   logic [7:0] display;
   logic [9:0] indicator;

   button_press_counter_top #(
      .DEBOUNCE_CYCLES(D),
      .SYNC_STAGES(S)
   ) dut (
      .clk(clk),
      .rst(rst),
      .activator(activator),
      .buttons(buttons),
      .equalizer(equalizer),
      .display(display),
      .indicator(indicator)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   typedef struct packed {
      logic       act;
      logic [2:0] btn;
      logic [2:0] eq;
   } in_t;

   in_t        hist[$];
   logic [3:0] m_cnt [3];
   int         m_last;
   logic       m_act;
   logic [6:0] seg [16];

   function automatic logic [7:0] m_disp();
      logic eq;
      eq = (m_cnt[0] == m_cnt[1]) && (m_cnt[1] == m_cnt[2]);
      return {eq, seg[m_cnt[m_last]]};
   endfunction

   function automatic logic [9:0] m_ind();
      int         tot;
      logic [10:0] t;
      tot = int'(m_cnt[0]) + int'(m_cnt[1]) + int'(m_cnt[2]);
      if (tot > 10) tot = 10;
      t = (11'd1 << tot) - 11'd1;
      return t[9:0];
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int j = 0; j < L; j++) hist.push_back('0);
      for (int i = 0; i < 3; i++) m_cnt[i] = '0;
      m_last = 0;
      m_act  = 1'b0;
   endtask

   // hist[j] holds the inputs sampled j edges ago; the core sees them S edges late.
   task automatic model_step(input logic a, input logic [2:0] b, input logic [2:0] e);
      in_t        s, p;
      logic [2:0] ev;
      logic [3:0] mx;
      logic [3:0] nc [3];
      bit         flip;
      in_t        cur;
      cur = '{act: a, btn: b, eq: e};
      hist.push_front(cur);
      void'(hist.pop_back());
      s  = hist[S];
      p  = hist[S+1];
      ev = s.btn & ~p.btn;
      mx = m_cnt[0];
      for (int i = 1; i < 3; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
      for (int i = 0; i < 3; i++) nc[i] = m_cnt[i];
      if (m_act) begin
         for (int i = 0; i < 3; i++) begin
            if (ev[i]) begin
               nc[i]  = s.eq[i] ? mx : 4'(m_cnt[i] + 4'd1);
               m_last = i;
            end
         end
      end
      flip = 1'b1;
      for (int k = 0; k < D; k++) if (hist[S+k].act == m_act) flip = 1'b0;
      if (flip) m_act = ~m_act;
      for (int i = 0; i < 3; i++) m_cnt[i] = nc[i];
   endtask

   task automatic chk_const(input string nm, input logic [7:0] ed, input logic [9:0] ei);
      nchk++;
      if (display !== ed || indicator !== ei) begin
         nerr++;
         $display("FAIL %s: display=%h indicator=%h, want display=%h indicator=%h",
                  nm, display, indicator, ed, ei);
      end
   endtask

   task automatic chk_model(input string nm);
      logic [7:0] ed;
      logic [9:0] ei;
      ed = m_disp();
      ei = m_ind();
      nchk++;
      if (display !== ed || indicator !== ei) begin
         nerr++;
         $display("FAIL %s @%0t: display=%h indicator=%h, model display=%h indicator=%h",
                  nm, $time, display, indicator, ed, ei);
      end
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic apply(input logic a, input logic [2:0] b, input logic [2:0] e);
      activator = a;
      buttons   = b;
      equalizer = e;
      @(posedge clk);
      model_step(a, b, e);
      @(negedge clk);
      chk_model("model");
   endtask

   task automatic do_reset(input string nm);
      #2 rst = 1'b1;
      model_reset();
      #1 chk_const(nm, 8'hC0, 10'h000);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      bit         rs;
      bit         act;
      logic [2:0] btn;
      logic [2:0] eq;
      int         n;
      bit         pulse;
      bit         chk;
      logic [7:0] ed;
      logic [9:0] ei;
   } row_t;

   row_t tbl[$];

   initial begin
      logic       ra;
      logic       a;
      logic [2:0] b, e;
      seg[0]  = 7'b1000000; seg[1]  = 7'b1111001; seg[2]  = 7'b0100100;
      seg[3]  = 7'b0110000; seg[4]  = 7'b0011001; seg[5]  = 7'b0010010;
      seg[6]  = 7'b0000010; seg[7]  = 7'b1111000; seg[8]  = 7'b0000000;
      seg[9]  = 7'b0010000; seg[10] = 7'b0001000; seg[11] = 7'b0000011;
      seg[12] = 7'b1000110; seg[13] = 7'b0100001; seg[14] = 7'b0000110;
      seg[15] = 7'b0001110;

      // count on buttons[2]
      tbl.push_back('{0, 1, 3'b000, 3'b000, 10, 0, 1, 8'hC0, 10'h000});
      tbl.push_back('{0, 1, 3'b100, 3'b000, 3, 1, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 1, 3'b000, 3'b000, 3, 0, 1, 8'h30, 10'h007});
      // equalize cnt0 to the max
      tbl.push_back('{0, 1, 3'b001, 3'b001, 1, 1, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 1, 3'b000, 3'b001, 3, 0, 1, 8'h30, 10'h03F});
      // long activator drop gates presses
      tbl.push_back('{0, 0, 3'b000, 3'b001, 10, 0, 1, 8'h30, 10'h03F});
      tbl.push_back('{0, 0, 3'b010, 3'b001, 1, 1, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 0, 3'b000, 3'b001, 3, 0, 1, 8'h30, 10'h03F});
      tbl.push_back('{0, 1, 3'b000, 3'b001, 10, 0, 1, 8'h30, 10'h03F});
      // 2-cycle glitch does not drop the debounced activator
      tbl.push_back('{0, 0, 3'b000, 3'b000, 1, 0, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 0, 3'b010, 3'b000, 1, 0, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 1, 3'b000, 3'b000, 4, 0, 1, 8'h79, 10'h07F});
      // wrap after 16 presses, then clamp
      tbl.push_back('{0, 1, 3'b010, 3'b000, 16, 1, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 1, 3'b000, 3'b000, 3, 0, 1, 8'h79, 10'h07F});
      tbl.push_back('{0, 1, 3'b010, 3'b000, 4, 1, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 1, 3'b000, 3'b000, 3, 0, 1, 8'h12, 10'h3FF});
      // mid-run reset
      tbl.push_back('{1, 0, 3'b000, 3'b000, 0, 0, 1, 8'hC0, 10'h000});
      // build 2/5/0, then simultaneous press with equalizer[0]
      tbl.push_back('{0, 1, 3'b000, 3'b000, 10, 0, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 1, 3'b001, 3'b000, 2, 1, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 1, 3'b010, 3'b000, 5, 1, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 1, 3'b000, 3'b000, 3, 0, 1, 8'h12, 10'h07F});
      tbl.push_back('{0, 1, 3'b011, 3'b001, 1, 1, 0, 8'h00, 10'h000});
      tbl.push_back('{0, 1, 3'b000, 3'b001, 3, 0, 1, 8'h02, 10'h3FF});

      model_reset();
      #1 chk_const("reset_init", 8'hC0, 10'h000);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[r]) begin
         if (tbl[r].rs) begin
            do_reset($sformatf("row%0d_reset", r));
         end else begin
            for (int n = 0; n < tbl[r].n; n++) begin
               apply(tbl[r].act, tbl[r].btn, tbl[r].eq);
               if (tbl[r].pulse) apply(tbl[r].act, 3'b000, tbl[r].eq);
            end
            if (tbl[r].chk)
               chk_const($sformatf("row%0d", r), tbl[r].ed, tbl[r].ei);
         end
      end

      // held press on buttons[2]: lands exactly two edges later, counted once
      apply(1'b1, 3'b100, 3'b000);
      chk_const("lat_edge1", 8'h02, 10'h3FF);
      apply(1'b1, 3'b100, 3'b000);
      chk_const("lat_edge2", 8'h02, 10'h3FF);
      apply(1'b1, 3'b100, 3'b000);
      chk_const("lat_edge3", 8'h79, 10'h3FF);
      for (int n = 0; n < 5; n++) apply(1'b1, 3'b100, 3'b000);
      chk_const("held_once", 8'h79, 10'h3FF);
      for (int n = 0; n < 3; n++) apply(1'b1, 3'b000, 3'b000);
      chk_const("release", 8'h79, 10'h3FF);

      // equalize 0 and 2 from 5/6/1 -> all six, all-equal flag set
      apply(1'b1, 3'b101, 3'b101);
      for (int n = 0; n < 3; n++) apply(1'b1, 3'b000, 3'b000);
      chk_const("all_equal", 8'h82, 10'h3FF);

      // random phase against the model
      ra = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset("rand_reset");
         end else begin
            if ($urandom_range(0, 29) == 0) ra = ~ra;
            a = ra;
            if ($urandom_range(0, 14) == 0) a = ~ra;
            b = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            e = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            apply(a, b, e);
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
